// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit-opcode CPU: sequencer state encoding,
// opcode values and instruction field positions. control_matrix imports this too.
package cpu_pkg;

  // Encodings are fixed because control_matrix decodes them directly.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } seq_state_t;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_JMP  = 4'b0001;
  localparam logic [3:0] OP_LDW  = 4'b0010;
  localparam logic [3:0] OP_STW  = 4'b0011;
  localparam logic [3:0] OP_RTR  = 4'b0100;
  localparam logic [3:0] OP_BLT  = 4'b0101;
  localparam logic [3:0] OP_ADD  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_HALT = 4'b1111;

  // Field positions within the instruction word (LSB of each 4-bit slice).
  localparam int OPC_LSB = 12;
  localparam int FA_LSB  = 8;
  localparam int FB_LSB  = 4;
  localparam int FC_LSB  = 0;

  // Opcodes 1000..1110 are unassigned; 1111 is HALT.
  function automatic logic is_illegal(input logic [3:0] op);
    return op[3] && (op != OP_HALT);
  endfunction

endpackage

// File: rtl/wait_timer.sv
// 4-bit handshake wait counter shared by FETCH and MEM. timeout_o flags the
// last permitted wait cycle, so a handshake still missing then ends the wait.
module wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic timeout_o
);

  localparam logic [3:0] LAST = 4'(TIMEOUT - 1);

  logic [3:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count waited cycles without wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)                   cnt_d = 4'd0;
    else if (en_i && cnt_q != 4'hF) cnt_d = cnt_q + 4'd1;
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= 4'd0;
    else        cnt_q <= cnt_d;
  end

  assign timeout_o = (cnt_q == LAST);

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer: owns the instruction register, drives the
// state/opcode/branch_flag inputs of control_matrix and handshakes with
// instruction and data memory. All status outputs are Moore (register-only).
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               step,
  input  logic [INSTR_W-1:0] instr_data,
  input  logic               instr_valid,
  input  logic               mem_ready,
  output logic               fetch_req,
  output logic               mem_req,
  output logic [2:0]         state,
  output logic [3:0]         opcode,
  output logic [3:0]         field_a,
  output logic [3:0]         field_b,
  output logic [3:0]         field_c,
  output logic               branch_flag,
  output logic               halted,
  output logic               fault,
  output logic [CNT_W-1:0]   retired
);

  // Handshake: fetch_req / mem_req stay high for every cycle spent in
  // FETCH / MEM; the cycle on which instr_valid / mem_ready is seen high
  // completes the transfer and the request drops on the next state.

  seq_state_t         state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               retire;
  logic               tmr_clear, tmr_en, tmr_timeout;
  logic [3:0]         op;
  seq_state_t         cont_state;

  assign op         = ir_q[OPC_LSB +: 4];
  assign cont_state = run ? S_FETCH : S_IDLE;

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (tmr_clear),
    .en_i      (tmr_en),
    .timeout_o (tmr_timeout)
  );

  // Next-state, IR capture and retire decision.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE:   if (run || step) state_d = S_FETCH;
      S_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr_data;
          state_d = S_DECODE;
        end else if (tmr_timeout) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        if (op == OP_HALT)     state_d = S_HALT;
        else if (is_illegal(op)) state_d = S_FAULT;
        else                   state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op)
          OP_LDW, OP_STW: state_d = S_MEM;
          OP_JMP, OP_BLT: begin
            retire  = 1'b1;
            state_d = cont_state;
          end
          OP_NOP, OP_RTR, OP_ADD, OP_SUB: state_d = S_WB;
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (op == OP_LDW) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = cont_state;
          end
        end else if (tmr_timeout) begin
          state_d = S_FAULT;
        end
      end
      S_WB: begin
        retire  = 1'b1;
        state_d = cont_state;
      end
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase

    // Timer restarts on every state entry and counts only unanswered waits.
    tmr_clear = (state_d != state_q);
    tmr_en    = ((state_q == S_FETCH) && !instr_valid) ||
                ((state_q == S_MEM) && !mem_ready);

    retired_d = retired_q;
    if (retire && (retired_q != {CNT_W{1'b1}})) retired_d = retired_q + 1'b1;
  end

  // State, IR and retire counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  assign state       = state_q;
  assign fetch_req   = (state_q == S_FETCH);
  assign mem_req     = (state_q == S_MEM);
  assign halted      = (state_q == S_HALT);
  assign fault       = (state_q == S_FAULT);
  assign branch_flag = (state_q == S_EXEC) && ((op == OP_JMP) || (op == OP_BLT));
  assign opcode      = op;
  assign field_a     = ir_q[FA_LSB +: 4];
  assign field_b     = ir_q[FB_LSB +: 4];
  assign field_c     = ir_q[FC_LSB +: 4];
  assign retired     = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: one task per scenario, inline checks.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run, step;
  logic [15:0] instr_data;
  logic        instr_valid, mem_ready;
  logic        fetch_req, mem_req, branch_flag, halted, fault;
  logic [2:0]  state;
  logic [3:0]  opcode, field_a, field_b, field_c;
  logic [15:0] retired;

  int errors = 0;
  int checks = 0;

  // Clock
  always #5 clk = ~clk;

  instr_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .step        (step),
    .instr_data  (instr_data),
    .instr_valid (instr_valid),
    .mem_ready   (mem_ready),
    .fetch_req   (fetch_req),
    .mem_req     (mem_req),
    .state       (state),
    .opcode      (opcode),
    .field_a     (field_a),
    .field_b     (field_b),
    .field_c     (field_c),
    .branch_flag (branch_flag),
    .halted      (halted),
    .fault       (fault),
    .retired     (retired)
  );

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive all inputs idle and hold reset for two edges.
  task automatic do_reset();
    reset = 1'b0; run = 1'b0; step = 1'b0;
    instr_valid = 1'b0; instr_data = 16'h0; mem_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (state !== 3'd0 || fetch_req !== 1'b0 || mem_req !== 1'b0 ||
        halted !== 1'b0 || fault !== 1'b0 || branch_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: state=%0d fr=%b mr=%b h=%b f=%b bf=%b want all 0",
               state, fetch_req, mem_req, halted, fault, branch_flag);
    end
    checks++;
    if (retired !== 16'd0 || opcode !== 4'd0 || field_a !== 4'd0 ||
        field_b !== 4'd0 || field_c !== 4'd0) begin
      errors++;
      $display("FAIL reset_data: retired=%0d op=%h fields=%h%h%h want 0",
               retired, opcode, field_a, field_b, field_c);
    end
  endtask

  // ADD 0x6123 then LDW 0x2450, free running with zero-wait memories.
  task automatic test_alu_ldw();
    logic [2:0] exp_q[$];
    logic [2:0] e;
    do_reset();
    exp_q = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1};
    run = 1'b1; instr_valid = 1'b1; mem_ready = 1'b1; instr_data = 16'h6123;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) instr_data = 16'h2450;
      tick();
      e = exp_q.pop_front();
      checks++;
      if (state !== e) begin
        errors++;
        $display("FAIL alu_ldw_state[%0d]: got %0d want %0d", i, state, e);
      end
      if (i == 1) begin
        checks++;
        if (opcode !== 4'h6 || field_a !== 4'h1 || field_b !== 4'h2 || field_c !== 4'h3) begin
          errors++;
          $display("FAIL add_ir: got %h%h%h%h want 6123", opcode, field_a, field_b, field_c);
        end
      end
      if (i == 4) begin
        checks++;
        if (retired !== 16'd1) begin
          errors++;
          $display("FAIL add_retire: got %0d want 1", retired);
        end
      end
      if (i == 7) begin
        checks++;
        if (mem_req !== 1'b1 || opcode !== 4'h2 || field_a !== 4'h4 || field_b !== 4'h5) begin
          errors++;
          $display("FAIL ldw_mem: mem_req=%b op=%h a=%h b=%h want 1 2 4 5",
                   mem_req, opcode, field_a, field_b);
        end
      end
    end
    checks++;
    if (retired !== 16'd2) begin
      errors++;
      $display("FAIL alu_ldw_retire: got %0d want 2", retired);
    end
  endtask

  // JMP: branch_flag only in EXEC, back to FETCH after 3 cycles.
  task automatic test_jmp();
    logic [2:0] exp_s[4];
    logic       exp_b[4];
    do_reset();
    exp_s = '{3'd1, 3'd2, 3'd3, 3'd1};
    exp_b = '{1'b0, 1'b0, 1'b1, 1'b0};
    run = 1'b1; instr_valid = 1'b1; instr_data = 16'h1000;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (state !== exp_s[i] || branch_flag !== exp_b[i]) begin
        errors++;
        $display("FAIL jmp[%0d]: state=%0d bf=%b want %0d %b",
                 i, state, branch_flag, exp_s[i], exp_b[i]);
      end
    end
    checks++;
    if (retired !== 16'd1) begin
      errors++;
      $display("FAIL jmp_retire: got %0d want 1", retired);
    end
  endtask

  // STW with zero-wait data memory: 4 cycles, retires from MEM.
  task automatic test_stw();
    logic [2:0] exp_s[5];
    do_reset();
    exp_s = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
    run = 1'b1; instr_valid = 1'b1; mem_ready = 1'b1; instr_data = 16'h3000;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (state !== exp_s[i]) begin
        errors++;
        $display("FAIL stw[%0d]: got %0d want %0d", i, state, exp_s[i]);
      end
    end
    checks++;
    if (retired !== 16'd1) begin
      errors++;
      $display("FAIL stw_retire: got %0d want 1", retired);
    end
  endtask

  // Single step of a NOP, then the sequencer rests in IDLE.
  task automatic test_step();
    logic [2:0] exp_s[6];
    do_reset();
    exp_s = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd0, 3'd0};
    step = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      step = 1'b0; instr_valid = 1'b1; instr_data = 16'h0000;
      checks++;
      if (state !== exp_s[i]) begin
        errors++;
        $display("FAIL step[%0d]: got %0d want %0d", i, state, exp_s[i]);
      end
    end
    checks++;
    if (retired !== 16'd1) begin
      errors++;
      $display("FAIL step_retire: got %0d want 1", retired);
    end
  endtask

  // HALT absorbs regardless of run; illegal opcodes go to FAULT.
  task automatic test_halt_illegal();
    do_reset();
    run = 1'b1; instr_valid = 1'b1; instr_data = 16'hF000;
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      run = i[0];
      tick();
      checks++;
      if (state !== 3'd6 || halted !== 1'b1 || fault !== 1'b0 || retired !== 16'd0) begin
        errors++;
        $display("FAIL halt[%0d]: state=%0d h=%b f=%b ret=%0d want 6 1 0 0",
                 i, state, halted, fault, retired);
      end
    end
    do_reset();
    run = 1'b1; instr_valid = 1'b1; instr_data = 16'h9000;
    repeat (3) tick();
    checks++;
    if (state !== 3'd7 || fault !== 1'b1 || halted !== 1'b0 || opcode !== 4'h9) begin
      errors++;
      $display("FAIL illegal: state=%0d f=%b h=%b op=%h want 7 1 0 9",
               state, fault, halted, opcode);
    end
  endtask

  // FETCH with instr_valid held low: fault after 15 wait cycles, not 14.
  task automatic test_fetch_timeout();
    do_reset();
    run = 1'b1;
    tick();
    repeat (14) tick();
    checks++;
    if (state !== 3'd1 || fetch_req !== 1'b1) begin
      errors++;
      $display("FAIL fetch_wait14: state=%0d fr=%b want 1 1", state, fetch_req);
    end
    tick();
    checks++;
    if (state !== 3'd7 || fault !== 1'b1 || fetch_req !== 1'b0) begin
      errors++;
      $display("FAIL fetch_timeout: state=%0d f=%b fr=%b want 7 1 0", state, fault, fetch_req);
    end
  endtask

  // LDW with mem_ready on MEM cycle 14 proceeds; STW with none faults at 15.
  task automatic test_mem_wait();
    do_reset();
    run = 1'b1; instr_valid = 1'b1; instr_data = 16'h2450;
    repeat (4) tick();
    instr_valid = 1'b0;
    repeat (13) tick();
    checks++;
    if (state !== 3'd4 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL mem_wait13: state=%0d mr=%b want 4 1", state, mem_req);
    end
    mem_ready = 1'b1;
    tick();
    checks++;
    if (state !== 3'd5 || fault !== 1'b0) begin
      errors++;
      $display("FAIL mem_late_ready: state=%0d f=%b want 5 0", state, fault);
    end
    do_reset();
    run = 1'b1; instr_valid = 1'b1; instr_data = 16'h3000;
    repeat (4) tick();
    instr_valid = 1'b0;
    repeat (14) tick();
    checks++;
    if (state !== 3'd4) begin
      errors++;
      $display("FAIL mem_wait14: got %0d want 4", state);
    end
    tick();
    checks++;
    if (state !== 3'd7 || retired !== 16'd0) begin
      errors++;
      $display("FAIL mem_timeout: state=%0d ret=%0d want 7 0", state, retired);
    end
  endtask

  // One-cycle reset pulse while MEM waits on mem_ready.
  task automatic test_reset_mid_mem();
    do_reset();
    run = 1'b1; instr_valid = 1'b1; instr_data = 16'h2450;
    repeat (6) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1; run = 1'b0; instr_valid = 1'b0;
    checks++;
    if (state !== 3'd0 || fetch_req !== 1'b0 || mem_req !== 1'b0 || retired !== 16'd0 ||
        opcode !== 4'd0 || field_a !== 4'd0 || field_b !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_mem: state=%0d fr=%b mr=%b ret=%0d op=%h a=%h b=%h want 0",
               state, fetch_req, mem_req, retired, opcode, field_a, field_b);
    end
  endtask

  initial begin
    test_reset();
    test_alu_ldw();
    test_jmp();
    test_stw();
    test_step();
    test_halt_illegal();
    test_fetch_timeout();
    test_mem_wait();
    test_reset_mid_mem();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
